ram_responder: RTL and testbench
================================

Name: ram_responder

Overview:
- Word-addressed synchronous memory that serves the datapath's memory requests.
- Samples the MAR address, the MDR write data and the Read/Write strobes, inserts a configurable number of wait states, then completes the access.
- Read data is driven onto Mdatain, which feeds the MDR's memory input; completion is signalled with a one-cycle mem_ready pulse.
- This is the memory-side responder to the datapath's MAR/MDR initiator.

Parameters:
- DEPTH, 512, number of 32-bit words; power of two.
- WAIT_STATES, 1, extra BUSY cycles per access; range 0..15.
- AW, 9, index width; equals log2(DEPTH).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- clear  input  1  synchronous, active-high reset.
- address  input  32  word address from MAR; only address[AW-1:0] indexes the array.
- data_in  input  32  write data from the MDR output.
- Read  input  1  read request, level; held until mem_ready is seen.
- Write  input  1  write request, level; held until mem_ready is seen.
- Mdatain  output  32  read data to the MDR; held between reads.
- mem_ready  output  1  one-cycle completion pulse.
- busy  output  1  high while in BUSY or DONE.
- addr_err  output  1  out-of-range flag; meaningful only with the optional feature.

Behaviour:
- Reset: a rising edge with clear=1 forces state=IDLE, wait counter=0, Mdatain=0, mem_ready=0, busy=0, addr_err=0.
  - Array contents are not cleared.
  - clear mid-access aborts the access. An uncommitted write is discarded and Mdatain is not updated.
  - clear has priority over every other event.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If Read or Write is 1 at the edge, latch address[AW-1:0], data_in and the op into internal registers.
  - If both are 1, Write wins: op=write, and Read is ignored for this access.
  - WAIT_STATES=0: go directly to DONE. Otherwise go to BUSY with counter=WAIT_STATES-1.
- BUSY: decrement the counter each edge. On the edge where counter==0, perform the access and go to DONE.
  - write: mem[idx] <= latched data.
  - read: Mdatain <= mem[idx].
  - For WAIT_STATES=0 this access happens on the IDLE->DONE edge.
- DONE: mem_ready=1 for exactly this cycle; next edge goes unconditionally to IDLE.
- Latency: request asserted in cycle 0 (accept edge ends cycle 0); mem_ready is high in cycle WAIT_STATES+1.
  - Back-to-back accesses take WAIT_STATES+2 cycles each.
- Initiator rule: drop Read/Write at the edge that ends the mem_ready cycle.
  - A strobe still high in IDLE starts a new access; this is legal and is not an error.
- Changes on address, data_in, Read or Write during BUSY/DONE are ignored; the latched values are used.
- Mdatain updates only on read completion. Writes, including writes to the last-read address, leave it unchanged.
- Without the optional feature, addresses wrap modulo DEPTH: the upper address bits are ignored.

Optional Feature:
- Macro: RAM_BOUNDS_CHECK_EN.
- Defined:
  - An access whose latched full 32-bit address is >= DEPTH still walks IDLE->BUSY->DONE with normal timing.
  - A write is suppressed; the array is unchanged.
  - A read loads Mdatain=0.
  - addr_err=1 during the DONE cycle alongside mem_ready, and is 0 otherwise.
- Undefined: addr_err is tied to 0, and addresses wrap as above.

Test Plan:
- Reset then idle: assert clear for 2 cycles -> Mdatain=0, mem_ready=0, busy=0; no mem_ready pulse for 10 idle cycles.
- Write then read, WAIT_STATES=1: Write address=0x54, data_in=0x00000097 -> mem_ready in cycle 2. Then Read address=0x54 -> Mdatain=0x00000097 with mem_ready in cycle 2, value held afterward.
- Simultaneous strobes: Read=Write=1, address=0x10, data_in=0xDEADBEEF -> write performed and Mdatain unchanged; a later read of 0x10 returns 0xDEADBEEF.
- Wrap, feature off, DEPTH=512: write 0x11111111 at address 0x205 -> read at address 0x005 returns 0x11111111.
- Reset mid-access, WAIT_STATES=3: Write 0x0F to address 0x20, assert clear on the second BUSY cycle -> no mem_ready; a subsequent read of 0x20 returns its prior value.
- RAM_BOUNDS_CHECK_EN: Write address=0x300 -> addr_err=1 with mem_ready and array unchanged; Read address=0x300 -> Mdatain=0 and addr_err=1.

Source files
------------

// File: rtl/ram_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_responder_if
// Brief    : MAR/MDR memory request bus between the datapath and the RAM.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_responder_if;
    logic [31:0] address;
    logic [31:0] data_in;
    logic        Read;
    logic        Write;
    logic [31:0] Mdatain;
    logic        mem_ready;
    logic        busy;
    logic        addr_err;

    modport master (
        output address, data_in, Read, Write,
        input  Mdatain, mem_ready, busy, addr_err
    );

    modport slave (
        input  address, data_in, Read, Write,
        output Mdatain, mem_ready, busy, addr_err
    );
endinterface
`default_nettype wire

// File: rtl/ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : ram_responder
// Brief    : Word-addressed RAM answering MAR/MDR requests after WAIT_STATES
//            wait cycles; optional range checking via RAM_BOUNDS_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ram_responder #(
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 1,
    parameter int AW          = 9
) (
    input  logic           clock,
    input  logic           clear,
    ram_responder_if.slave bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam bit         c_NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0] c_WAIT_LOAD = c_NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_nextState;
    logic [3:0]    r_waitCnt;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_wrData;
    logic          r_isWrite;
    logic          r_oob;
    logic [31:0]   r_mdatain;
    logic [31:0]   r_mem [DEPTH];

    logic          w_req;
    logic          w_start;
    logic          w_addrOob;
    logic          w_commit;
    logic          w_memWe;
    logic [AW-1:0] w_accIdx;
    logic [31:0]   w_accData;
    logic          w_accWrite;
    logic          w_accOob;

    assign w_req   = bus.Read | bus.Write;
    assign w_start = (r_state == c_IDLE) && w_req;

`ifdef RAM_BOUNDS_CHECK_EN
    assign w_addrOob    = (bus.address >= 32'(DEPTH));
    assign bus.addr_err = (r_state == c_DONE) && r_oob;
`else
    assign w_addrOob    = 1'b0;
    assign bus.addr_err = 1'b0;
`endif

    always_comb begin
        w_nextState = r_state;
        w_commit    = 1'b0;
        w_accIdx    = r_idx;
        w_accData   = r_wrData;
        w_accWrite  = r_isWrite;
        w_accOob    = r_oob;
        case (r_state)
            c_IDLE: begin
                if (w_req) begin
                    if (c_NO_WAIT) begin
                        // Zero wait states: the access uses the live request on the accept edge.
                        w_nextState = c_DONE;
                        w_commit    = 1'b1;
                        w_accIdx    = bus.address[AW-1:0];
                        w_accData   = bus.data_in;
                        w_accWrite  = bus.Write;
                        w_accOob    = w_addrOob;
                    end else begin
                        w_nextState = c_BUSY;
                    end
                end
            end
            c_BUSY: begin
                if (r_waitCnt == 4'd0) begin
                    w_nextState = c_DONE;
                    w_commit    = 1'b1;
                end
            end
            c_DONE:  w_nextState = c_IDLE;
            default: w_nextState = c_IDLE;
        endcase
    end

    assign w_memWe = w_commit && w_accWrite && !w_accOob && !clear;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state   <= c_IDLE;
            r_waitCnt <= 4'd0;
            r_mdatain <= 32'd0;
            r_oob     <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_start) begin
                r_idx     <= bus.address[AW-1:0];
                r_wrData  <= bus.data_in;
                r_isWrite <= bus.Write;
                r_oob     <= w_addrOob;
                r_waitCnt <= c_WAIT_LOAD;
            end else if ((r_state == c_BUSY) && (r_waitCnt != 4'd0)) begin
                r_waitCnt <= r_waitCnt - 4'd1;
            end
            if (w_commit && !w_accWrite) begin
                r_mdatain <= w_accOob ? 32'd0 : r_mem[w_accIdx];
            end
        end
    end

    // Array contents survive clear; only the pending commit is gated.
    always_ff @(posedge clock) begin
        if (w_memWe) begin
            r_mem[w_accIdx] <= w_accData;
        end
    end

    assign bus.Mdatain   = r_mdatain;
    assign bus.mem_ready = (r_state == c_DONE);
    assign bus.busy      = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_responder
// Brief    : Directed self-checking bench for ram_responder (WAIT_STATES 1 and 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_responder;

    logic clk    = 1'b0;
    logic clearA = 1'b1;
    logic clearB = 1'b1;
    int   assertCnt = 0;
    int   failCnt   = 0;

    ram_responder_if busA ();
    ram_responder_if busB ();

    ram_responder #(.DEPTH(512), .WAIT_STATES(1), .AW(9)) u_dutA (
        .clock (clk),
        .clear (clearA),
        .bus   (busA.slave)
    );

    ram_responder #(.DEPTH(512), .WAIT_STATES(3), .AW(9)) u_dutB (
        .clock (clk),
        .clear (clearB),
        .bus   (busB.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCnt++;
        if (obs !== exp) begin
            failCnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic readyOf(input bit sel);
        return sel ? busB.mem_ready : busA.mem_ready;
    endfunction

    function automatic logic errOf(input bit sel);
        return sel ? busB.addr_err : busA.addr_err;
    endfunction

    task automatic drive(input bit sel, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data);
        if (sel) begin
            busB.Read = rd; busB.Write = wr; busB.address = addr; busB.data_in = data;
        end else begin
            busA.Read = rd; busA.Write = wr; busA.address = addr; busA.data_in = data;
        end
    endtask

    // Returns the cycle index in which mem_ready was seen (request cycle = 0).
    task automatic access(input bit sel, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data,
                          output int lat, output logic errAtReady);
        @(negedge clk);
        drive(sel, rd, wr, addr, data);
        @(posedge clk); #1;
        lat = 1;
        while (!readyOf(sel) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        errAtReady = errOf(sel);
        drive(sel, 1'b0, 1'b0, addr, data);
        @(posedge clk); #1;
        chk("pulse_width", 32'(readyOf(sel)), 32'd0);
    endtask

    int   lat;
    logic err;
    int   pulses;

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

        // Reset and idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        clearA = 1'b0;
        clearB = 1'b0;
        chk("rst_mdatain", busA.Mdatain, 32'd0);
        chk("rst_ready",   32'(busA.mem_ready), 32'd0);
        chk("rst_busy",    32'(busA.busy), 32'd0);
        chk("rst_err",     32'(busA.addr_err), 32'd0);
        pulses = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (busA.mem_ready) pulses++;
        end
        chk("idle_pulses", 32'(pulses), 32'd0);

        // Write then read with one wait state
        access(1'b0, 1'b0, 1'b1, 32'h54, 32'h97, lat, err);
        chk("wr54_lat", 32'(lat), 32'd2);
        chk("wr54_mdatain", busA.Mdatain, 32'd0);
        access(1'b0, 1'b1, 1'b0, 32'h54, 32'hFFFF_FFFF, lat, err);
        chk("rd54_lat", 32'(lat), 32'd2);
        chk("rd54_data", busA.Mdatain, 32'h97);
        repeat (3) @(posedge clk);
        #1 chk("rd54_hold", busA.Mdatain, 32'h97);

        // Busy visible during the wait state
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h54, 32'd0);
        @(posedge clk); #1;
        chk("busy_wait", 32'(busA.busy), 32'd1);
        chk("ready_early", 32'(busA.mem_ready), 32'd0);
        @(posedge clk); #1;
        chk("busy_done", 32'(busA.busy), 32'd1);
        chk("ready_done", 32'(busA.mem_ready), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        chk("busy_idle", 32'(busA.busy), 32'd0);

        // Simultaneous strobes: write wins
        access(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, lat, err);
        chk("both_lat", 32'(lat), 32'd2);
        chk("both_mdatain", busA.Mdatain, 32'h97);
        access(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, lat, err);
        chk("rd10_data", busA.Mdatain, 32'hDEAD_BEEF);

        // Write to last-read address leaves Mdatain alone
        access(1'b0, 1'b0, 1'b1, 32'h10, 32'h0BAD_F00D, lat, err);
        chk("wr_lastrd_hold", busA.Mdatain, 32'hDEAD_BEEF);
        access(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, lat, err);
        chk("rd10_new", busA.Mdatain, 32'h0BAD_F00D);

`ifdef RAM_BOUNDS_CHECK_EN
        // 0x300 would alias index 0x100 if it were not rejected
        access(1'b0, 1'b0, 1'b1, 32'h100, 32'hCAFE_F00D, lat, err);
        chk("oob_pre_err", 32'(err), 32'd0);
        access(1'b0, 1'b0, 1'b1, 32'h300, 32'h1234_5678, lat, err);
        chk("oob_wr_lat", 32'(lat), 32'd2);
        chk("oob_wr_err", 32'(err), 32'd1);
        access(1'b0, 1'b1, 1'b0, 32'h100, 32'd0, lat, err);
        chk("oob_array_kept", busA.Mdatain, 32'hCAFE_F00D);
        chk("inrange_err", 32'(err), 32'd0);
        access(1'b0, 1'b1, 1'b0, 32'h300, 32'd0, lat, err);
        chk("oob_rd_data", busA.Mdatain, 32'd0);
        chk("oob_rd_err", 32'(err), 32'd1);
        #1 chk("oob_err_after", 32'(busA.addr_err), 32'd0);
`else
        // Upper address bits ignored
        access(1'b0, 1'b0, 1'b1, 32'h205, 32'h1111_1111, lat, err);
        chk("wrap_wr_err", 32'(err), 32'd0);
        access(1'b0, 1'b1, 1'b0, 32'h005, 32'd0, lat, err);
        chk("wrap_rd_data", busA.Mdatain, 32'h1111_1111);
        chk("wrap_rd_err", 32'(err), 32'd0);
`endif

        // Three wait states: baseline value, then aborted write
        access(1'b1, 1'b0, 1'b1, 32'h20, 32'hAAAA_0001, lat, err);
        chk("b_wr_lat", 32'(lat), 32'd4);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 32'h20, 32'h0000_000F);
        @(posedge clk); #1;
        chk("b_busy1", 32'(busB.busy), 32'd1);
        @(posedge clk); #1;
        clearB = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h20, 32'd0);
        @(posedge clk); #1;
        clearB = 1'b0;
        chk("b_abort_busy", 32'(busB.busy), 32'd0);
        pulses = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (busB.mem_ready) pulses++;
        end
        chk("b_abort_pulses", 32'(pulses), 32'd0);
        chk("b_abort_mdatain", busB.Mdatain, 32'd0);
        access(1'b1, 1'b1, 1'b0, 32'h20, 32'd0, lat, err);
        chk("b_rd_lat", 32'(lat), 32'd4);
        chk("b_rd_data", busB.Mdatain, 32'hAAAA_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
`default_nettype wire
